// File: rtl/dac_slew_limiter_if.sv
// Command bus for dac_slew_limiter: strobe, address, write data and registered read data.
interface dac_slew_limiter_if;
    logic        cmd_trig_in;
    logic [15:0] cmd_addr_in;
    logic [15:0] cmd_data_in;
    logic [15:0] cmd_data_out;

    modport master (
        output cmd_trig_in,
        output cmd_addr_in,
        output cmd_data_in,
        input  cmd_data_out
    );

    modport slave (
        input  cmd_trig_in,
        input  cmd_addr_in,
        input  cmd_data_in,
        output cmd_data_out
    );
endinterface

// File: rtl/dac_slew_limiter.sv
// Two-channel DAC sample conditioner: offset with saturation, min/max clamp and a
// per-sample slew limit, configured through a 16-bit command bus.
module dac_slew_limiter #(
    parameter logic [15:0] RESET_MIN = 16'h8000,
    parameter logic [15:0] RESET_MAX = 16'h7FFF
) (
    input  logic                clk_in,
    input  logic                rst_in,
    dac_slew_limiter_if.slave   cmd,
    input  logic signed [15:0]  DAC0_in,
    input  logic signed [15:0]  DAC1_in,
    output logic signed [15:0]  DAC0_out,
    output logic signed [15:0]  DAC1_out,
    output logic [1:0]          rail_out
);

    localparam logic signed [16:0] SAT_MAX = 17'sd32767;
    localparam logic signed [16:0] SAT_MIN = -17'sd32768;

    logic        wr_en;
    logic        rd_en;
    logic [7:0]  addr_lo;
    logic [15:0] rd_ch [2];
    logic [15:0] rd_data;
    logic [15:0] rd_data_reg;
    logic [1:0]  status_reg;
    logic [1:0]  status_clr;

    assign addr_lo = cmd.cmd_addr_in[7:0];
    assign wr_en   = cmd.cmd_trig_in && (cmd.cmd_addr_in[15:8] == 8'h23);
    assign rd_en   = cmd.cmd_trig_in && (cmd.cmd_addr_in[15:8] == 8'h22);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : ch
            localparam logic [7:0] BASE = 8'(gi * 16);

            logic signed [15:0] sample;
            logic signed [15:0] offset_reg;
            logic signed [15:0] min_reg;
            logic signed [15:0] max_reg;
            logic [15:0]        step_reg;
            logic [1:0]         ctrl_reg;
            logic signed [15:0] sum_reg;
            logic signed [15:0] target_reg;
            logic               rail_reg;
            logic signed [15:0] out_reg;

            logic signed [16:0] sum_wide;
            logic signed [15:0] sum_next;
            logic signed [15:0] target_next;
            logic               rail_next;
            logic signed [17:0] diff;
            logic signed [17:0] step_wide;
            logic signed [15:0] out_next;
            logic [15:0]        rd_local;

            assign sample = (gi == 0) ? DAC0_in : DAC1_in;

            always_comb begin
                // Stage 1: offset add with saturation, optionally forced to zero.
                sum_wide = $signed({sample[15], sample}) + $signed({offset_reg[15], offset_reg});
                if (sum_wide > SAT_MAX) begin
                    sum_next = 16'sh7FFF;
                end else if (sum_wide < SAT_MIN) begin
                    sum_next = 16'sh8000;
                end else begin
                    sum_next = sum_wide[15:0];
                end
                if (ctrl_reg[1]) begin
                    sum_next = 16'sh0000;
                end

                // Stage 2: clamp; an inverted window collapses onto the lower bound.
                if (min_reg > max_reg) begin
                    target_next = min_reg;
                end else if (sum_reg < min_reg) begin
                    target_next = min_reg;
                end else if (sum_reg > max_reg) begin
                    target_next = max_reg;
                end else begin
                    target_next = sum_reg;
                end
                rail_next = (target_next != sum_reg);

                // Stage 3: step toward target; the step never overshoots so no wrap is possible.
                diff      = $signed({{2{target_reg[15]}}, target_reg}) - $signed({{2{out_reg[15]}}, out_reg});
                step_wide = $signed({2'b00, step_reg});
                if (step_reg == 16'd0) begin
                    out_next = target_reg;
                end else if (diff > step_wide) begin
                    out_next = out_reg + step_reg;
                end else if (diff < -step_wide) begin
                    out_next = out_reg - step_reg;
                end else begin
                    out_next = target_reg;
                end
                if (ctrl_reg[0]) begin
                    out_next = out_reg;
                end
            end

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    offset_reg <= '0;
                    min_reg    <= RESET_MIN;
                    max_reg    <= RESET_MAX;
                    step_reg   <= '0;
                    ctrl_reg   <= '0;
                    sum_reg    <= '0;
                    target_reg <= '0;
                    rail_reg   <= 1'b0;
                    out_reg    <= '0;
                end else begin
                    if (wr_en && addr_lo == BASE)         offset_reg <= cmd.cmd_data_in;
                    if (wr_en && addr_lo == BASE + 8'd1)  min_reg    <= cmd.cmd_data_in;
                    if (wr_en && addr_lo == BASE + 8'd2)  max_reg    <= cmd.cmd_data_in;
                    if (wr_en && addr_lo == BASE + 8'd3)  step_reg   <= cmd.cmd_data_in;
                    if (wr_en && addr_lo == BASE + 8'd4)  ctrl_reg   <= cmd.cmd_data_in[1:0];
                    sum_reg    <= sum_next;
                    target_reg <= target_next;
                    rail_reg   <= rail_next;
                    out_reg    <= out_next;
                end
            end

            always_comb begin
                rd_local = 16'h0000;
                case (addr_lo[3:0])
                    4'h0:    rd_local = offset_reg;
                    4'h1:    rd_local = min_reg;
                    4'h2:    rd_local = max_reg;
                    4'h3:    rd_local = step_reg;
                    4'h4:    rd_local = {14'b0, ctrl_reg};
                    default: rd_local = 16'h0000;
                endcase
            end
            assign rd_ch[gi]    = rd_local;
            assign rail_out[gi] = rail_reg;

            if (gi == 0) begin : g_out0
                assign DAC0_out = out_reg;
            end else begin : g_out1
                assign DAC1_out = out_reg;
            end
        end
    endgenerate

    always_comb begin
        rd_data = 16'h0000;
        case (addr_lo[7:4])
            4'h0:    rd_data = rd_ch[0];
            4'h1:    rd_data = rd_ch[1];
            4'h2:    rd_data = (addr_lo[3:0] == 4'h0) ? {14'b0, status_reg} : 16'h0000;
            default: rd_data = 16'h0000;
        endcase
    end

    assign status_clr = (wr_en && addr_lo == 8'h20) ? cmd.cmd_data_in[1:0] : 2'b00;

    // A live rail event overrides a same-cycle write-1-to-clear.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            status_reg  <= '0;
            rd_data_reg <= '0;
        end else begin
            status_reg <= (status_reg & ~status_clr) | rail_out;
            if (rd_en) begin
                rd_data_reg <= rd_data;
            end
        end
    end

    assign cmd.cmd_data_out = rd_data_reg;

endmodule

// File: tb/tb_dac_slew_limiter.sv
// Scoreboard bench for dac_slew_limiter: directed scenarios followed by randomized
// samples and commands, all checked against an integer reference model.
module tb_dac_slew_limiter;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] d0 = '0;
    logic signed [15:0] d1 = '0;
    logic signed [15:0] o0;
    logic signed [15:0] o1;
    logic [1:0]         rail;

    dac_slew_limiter_if cmd_bus ();

    dac_slew_limiter #(
        .RESET_MIN (16'h8000),
        .RESET_MAX (16'h7FFF)
    ) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .cmd      (cmd_bus),
        .DAC0_in  (d0),
        .DAC1_in  (d1),
        .DAC0_out (o0),
        .DAC1_out (o1),
        .rail_out (rail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] o0;
        logic [15:0] o1;
        logic [1:0]  rail;
        logic [15:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state, plain integers.
    int          m_off[2], m_min[2], m_max[2], m_step[2], m_hold[2], m_zero[2];
    int          m_sum[2], m_tgt[2], m_rail[2], m_out[2];
    int          m_status;
    logic [15:0] m_rd;

    logic signed [15:0] cur0 = '0;
    logic signed [15:0] cur1 = '0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [7:0] a);
        int c;
        c = (a[7:4] == 4'h1) ? 1 : 0;
        if (a == 8'h20) return 16'(m_status);
        if (a[7:4] > 4'h1) return 16'h0000;
        case (a[3:0])
            4'h0:    return 16'(m_off[c]);
            4'h1:    return 16'(m_min[c]);
            4'h2:    return 16'(m_max[c]);
            4'h3:    return 16'(m_step[c]);
            4'h4:    return 16'(m_hold[c] + 2 * m_zero[c]);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_off[c] = 0; m_min[c] = -32768; m_max[c] = 32767; m_step[c] = 0;
            m_hold[c] = 0; m_zero[c] = 0; m_sum[c] = 0; m_tgt[c] = 0;
            m_rail[c] = 0; m_out[c] = 0;
        end
        m_status = 0;
        m_rd     = 16'h0000;
    endtask

    task automatic model_edge(input logic r, input logic signed [15:0] s0, input logic signed [15:0] s1,
                              input logic trig, input logic [15:0] a, input logic [15:0] d);
        int samp[2];
        int s, t, diff, clr, c;
        exp_t e;
        if (r) begin
            model_reset();
        end else begin
            samp[0] = s0;
            samp[1] = s1;
            if (trig && a[15:8] == 8'h22) m_rd = model_read(a[7:0]);
            clr = (trig && a[15:8] == 8'h23 && a[7:0] == 8'h20) ? int'(d[1:0]) : 0;
            m_status = (m_status & ~clr) | (m_rail[0] + 2 * m_rail[1]);
            for (int k = 0; k < 2; k++) begin
                // Output moves toward the target that reached it last cycle.
                if (m_hold[k] == 0) begin
                    diff = m_tgt[k] - m_out[k];
                    if (m_step[k] == 0)            m_out[k] = m_tgt[k];
                    else if (diff > m_step[k])     m_out[k] = m_out[k] + m_step[k];
                    else if (diff < -m_step[k])    m_out[k] = m_out[k] - m_step[k];
                    else                           m_out[k] = m_tgt[k];
                end
                s = m_sum[k];
                if (m_min[k] > m_max[k]) t = m_min[k];
                else if (s < m_min[k])   t = m_min[k];
                else if (s > m_max[k])   t = m_max[k];
                else                     t = s;
                m_tgt[k]  = t;
                m_rail[k] = (t != s) ? 1 : 0;
                s = samp[k] + m_off[k];
                if (s > 32767)  s = 32767;
                if (s < -32768) s = -32768;
                m_sum[k] = (m_zero[k] != 0) ? 0 : s;
            end
            if (trig && a[15:8] == 8'h23 && a[7:4] <= 4'h1 && a[3:0] <= 4'h4) begin
                c = int'(a[4]);
                case (a[3:0])
                    4'h0:    m_off[c]  = int'($signed(d));
                    4'h1:    m_min[c]  = int'($signed(d));
                    4'h2:    m_max[c]  = int'($signed(d));
                    4'h3:    m_step[c] = int'(d);
                    default: begin m_hold[c] = int'(d[0]); m_zero[c] = int'(d[1]); end
                endcase
            end
        end
        e.o0   = 16'(m_out[0]);
        e.o1   = 16'(m_out[1]);
        e.rail = 2'(m_rail[0] + 2 * m_rail[1]);
        e.rd   = m_rd;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic trig, input logic [15:0] a, input logic [15:0] d);
        rst = r;
        d0 = cur0;
        d1 = cur1;
        cmd_bus.cmd_trig_in = trig;
        cmd_bus.cmd_addr_in = a;
        cmd_bus.cmd_data_in = d;
        if (trig) $display("cmd addr=%h data=%h rst=%0b", a, d, r);
        @(posedge clk);
        model_edge(r, cur0, cur1, trig, a, d);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cycle(1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [15:0] a);
        cycle(1'b0, 1'b1, a, 16'h0000);
    endtask

    // Monitor: every cycle's DUT outputs against the scoreboard entry for that edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("dac0", o0, e.o0);
            check("dac1", o1, e.o1);
            check("rail", {14'b0, rail}, {14'b0, e.rail});
            check("rdata", cmd_bus.cmd_data_out, e.rd);
        end
    end

    logic [7:0] lo_tab [14] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11,
                                8'h12, 8'h13, 8'h14, 8'h20, 8'h05, 8'h15, 8'h30};
    logic [7:0] hi_tab [6]  = '{8'h22, 8'h23, 8'h23, 8'h22, 8'h24, 8'h00};

    initial begin
        logic [7:0]  hi, lo;
        logic [15:0] data;
        model_reset();
        cmd_bus.cmd_trig_in = 1'b0;
        cmd_bus.cmd_addr_in = '0;
        cmd_bus.cmd_data_in = '0;

        cycle(1'b1, 1'b0, 16'h0, 16'h0);
        cycle(1'b1, 1'b1, 16'h2300, 16'h5555);
        idle(1);
        check("reset_dac0", o0, 16'h0000);
        check("reset_rail", {14'b0, rail}, 16'h0000);
        check("reset_rdata", cmd_bus.cmd_data_out, 16'h0000);

        // Pass-through latency.
        cur0 = 16'sh1234;
        idle(2);
        check("latency_early", o0, 16'h0000);
        idle(1);
        check("passthrough", o0, 16'h1234);
        check("passthrough_rail", {14'b0, rail}, 16'h0000);

        // Offset saturation is not clamping.
        wr(16'h2300, 16'h7000);
        cur0 = 16'sh7000;
        idle(4);
        check("offset_sat", o0, 16'h7FFF);
        check("offset_sat_rail0", {15'b0, rail[0]}, 16'h0000);
        wr(16'h2300, 16'h0000);

        // Clamp, sticky status, set-wins clear, then a real clear.
        cur1 = 16'sd500;
        wr(16'h2312, 16'd100);
        idle(4);
        check("clamp_max1", o1, 16'd100);
        check("clamp_rail1", {15'b0, rail[1]}, 16'h0001);
        rd(16'h2220);
        check("status_set", cmd_bus.cmd_data_out, 16'h0002);
        wr(16'h2320, 16'h0002);
        idle(1);
        rd(16'h2220);
        check("status_set_wins", cmd_bus.cmd_data_out, 16'h0002);
        cur1 = 16'sd50;
        idle(4);
        wr(16'h2320, 16'h0002);
        rd(16'h2220);
        check("status_cleared", cmd_bus.cmd_data_out, 16'h0000);
        wr(16'h2312, 16'h7FFF);

        // Slew ramp up, then a long ramp down, then reset mid-ramp.
        cur0 = 16'sd0;
        idle(4);
        wr(16'h2303, 16'd10);
        cur0 = 16'sd35;
        idle(2);
        idle(1); check("slew_10", o0, 16'd10);
        idle(1); check("slew_20", o0, 16'd20);
        idle(1); check("slew_30", o0, 16'd30);
        idle(1); check("slew_35", o0, 16'd35);
        cur0 = -16'sd32768;
        idle(2);
        idle(1); check("slew_down_25", o0, 16'd25);
        idle(1); check("slew_down_15", o0, 16'd15);
        idle(1); check("slew_down_5", o0, 16'd5);
        idle(1); check("slew_down_m5", o0, 16'hFFF6 + 16'd5);
        cycle(1'b1, 1'b0, 16'h0, 16'h0);
        check("reset_midslew_dac0", o0, 16'h0000);
        rd(16'h2203);
        check("reset_step_read", cmd_bus.cmd_data_out, 16'h0000);
        rd(16'h2202);
        check("reset_max_read", cmd_bus.cmd_data_out, 16'h7FFF);

        // Hold, zero, and an inverted clamp window.
        cur0 = 16'sd1000;
        idle(4);
        check("pre_hold", o0, 16'd1000);
        wr(16'h2304, 16'h0001);
        cur0 = -16'sd500;
        idle(5);
        check("hold_frozen", o0, 16'd1000);
        wr(16'h2303, 16'd100);
        wr(16'h2304, 16'h0002);
        idle(14);
        check("zero_slewed", o0, 16'h0000);
        wr(16'h2301, 16'd200);
        wr(16'h2302, 16'd100);
        idle(6);
        check("min_gt_max", o0, 16'd200);

        // Randomized traffic.
        cycle(1'b1, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 800; i++) begin
            cur0 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 400)) - 16'd200 : 16'($urandom);
            cur1 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 400)) - 16'd200 : 16'($urandom);
            hi = hi_tab[$urandom_range(0, 5)];
            lo = lo_tab[$urandom_range(0, 13)];
            if (lo[3:0] == 4'h3)      data = 16'($urandom_range(0, 2000));
            else if (lo[3:0] == 4'h4) data = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 3)) : 16'h0000;
            else                      data = 16'($urandom);
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, {hi, lo}, data);
        end
        idle(2);
        #1;
        check("scoreboard_drain", 16'(exp_q.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
